multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control unit for the microprocessor datapath. Sequences each instruction through
//  FETCH/DECODE/EXEC/MEM/WB, decodes opcode/funct into datapath controls, waits on memory ready
//  handshakes, and adds JAL, JR, NOP, HALT and illegal-instruction trap.
//  Sits between instruction register and datapath; drives PC, IR, register file, ALU and memory.
// PARAMETERS
//  OPC_W    6   opcode field width
//  FN_W     6   funct field width
//  ALU_W    4   alu_ctrl width
//  RA_REG   31  link register index driven on link_reg for JAL
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-low reset
//  opcode       in   OPC_W  IR opcode (valid from DECODE onward)
//  funct        in   FN_W   IR funct
//  zero         in   1      ALU zero flag, sampled in EXEC
//  stall        in   1      external stall; holds FSM in FETCH
//  resume       in   1      leaves HALT
//  mem_ready    in   1      memory completes current imem/dmem access
//  imem_req     out  1      instruction fetch request
//  ir_write     out  1      load IR (one cycle)
//  pc_write     out  1      update PC (one cycle)
//  pc_src       out  2      0 pc+4, 1 branch target, 2 jump target, 3 rs register
//  reg_dst      out  2      0 rt, 1 rd, 2 link_reg
//  link_reg     out  5      constant RA_REG
//  reg_write    out  1      register file write (one cycle, WB)
//  mem_to_reg   out  2      0 ALU, 1 memory data, 2 pc+4
//  alu_src      out  1      0 register, 1 immediate
//  ext_op       out  1      1 sign-extend, 0 zero-extend
//  mem_read     out  1      data read request
//  mem_write    out  1      data write request
//  alu_ctrl     out  ALU_W  add 0000 sub 0010 and 0100 nor 0101 sll 1010 srl 1011 idle 1111
//  instr_done   out  1      one-cycle pulse on instruction retirement
//  illegal      out  1      sticky; set in TRAP
//  halted       out  1      high while in HALT
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): state=FETCH, all outputs 0 except alu_ctrl=1111; illegal cleared.
//    Reset wins over every other input, any state, including mid memory wait.
//  - States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP. Controls are registered decodes of state+opcode.
//  - FETCH: if stall, hold with imem_req=0. Else imem_req=1 until mem_ready; on mem_ready cycle
//    ir_write=1, pc_write=1, pc_src=0, next DECODE.
//  - DECODE: classify opcode/funct. 111111 NOP -> instr_done, FETCH. 000110 -> HALT.
//    Unknown opcode or R-type funct -> TRAP. Others -> EXEC.
//  - EXEC: R-type (000000) alu_src=0, alu_ctrl per funct (100000 add, 100010 sub, 100100 and,
//    100111 nor, 000000 sll, 000010 srl) -> WB; funct 001000 JR: pc_write=1 pc_src=3, retire.
//    ADDI 001000 add, ext_op=1; ANDI 001100 and, ext_op=0; both alu_src=1 -> WB.
//    LW 110000 / SW 101011: add, alu_src=1, ext_op=1 -> MEM.
//    BEQ 000100 / BNE 000101: sub, alu_src=0; pc_write=1 pc_src=1 iff zero (BEQ) / !zero (BNE); retire.
//    J 000010: pc_write=1 pc_src=2, retire. JAL 000011: pc_write=1 pc_src=2 -> WB.
//  - MEM: LW holds mem_read=1, SW holds mem_write=1 until mem_ready. On mem_ready: SW retires,
//    LW -> WB. mem_read and mem_write never high together.
//  - WB: reg_write=1 one cycle; R-type reg_dst=1 mem_to_reg=0; ADDI/ANDI reg_dst=0 mem_to_reg=0;
//    LW reg_dst=0 mem_to_reg=1; JAL reg_dst=2 mem_to_reg=2. Retire.
//  - Retire: instr_done=1 that cycle, next FETCH.
//  - Latency (zero-wait memory): NOP 2, branch/J/JR 3, R/ADDI/ANDI/JAL/SW 4, LW 5 cycles; each
//    mem_ready-low cycle in FETCH/MEM adds one.
//  - HALT: outputs idle, halted=1; resume -> instr_done, FETCH. TRAP: illegal=1, outputs idle,
//    exit only by reset. stall ignored outside FETCH.
// TESTING
//  - ADD (op 000000 fn 100000), mem_ready=1 -> ir_write@c1, alu_ctrl=0000@c3, reg_write+reg_dst=1@c4, instr_done@c4.
//  - LW (110000) with mem_ready low 3 MEM cycles -> mem_read high 4 cycles, then WB mem_to_reg=1; total 8 cycles.
//  - BEQ zero=1 -> pc_write=1 pc_src=1 in EXEC; BNE zero=1 -> pc_write=0; both retire in 3 cycles.
//  - JAL (000011) -> pc_src=2 in EXEC, WB reg_dst=2 mem_to_reg=2 link_reg=31; JR fn 001000 -> pc_src=3.
//  - opcode 010101 -> TRAP, illegal=1 held 10 cycles; rst=0 one cycle -> FETCH, illegal=0.
//  - stall=1 in FETCH 5 cycles -> imem_req=0; opcode 000110 -> halted=1 until resume=1; rst=0 during MEM wait -> FETCH, mem_read=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory ready handshakes,
// jump/link support, HALT and an illegal-instruction trap. The decode is latched in DECODE.
module multicycle_ctrl #(
    parameter int OPC_W  = 6,
    parameter int FN_W   = 6,
    parameter int ALU_W  = 4,
    parameter int RA_REG = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic [FN_W-1:0]  funct,
    input  logic             zero,
    input  logic             stall,
    input  logic             resume,
    input  logic             mem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       reg_dst,
    output logic [4:0]       link_reg,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src,
    output logic             ext_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic             instr_done,
    output logic             illegal,
    output logic             halted
);
    localparam logic [OPC_W-1:0] OP_R    = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b000010);
    localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(6'b000011);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(6'b000101);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(6'b000110);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(6'b001100);
    localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b101011);
    localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b110000);
    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(6'b111111);

    localparam logic [FN_W-1:0] FN_ADD = FN_W'(6'b100000);
    localparam logic [FN_W-1:0] FN_SUB = FN_W'(6'b100010);
    localparam logic [FN_W-1:0] FN_AND = FN_W'(6'b100100);
    localparam logic [FN_W-1:0] FN_NOR = FN_W'(6'b100111);
    localparam logic [FN_W-1:0] FN_SLL = FN_W'(6'b000000);
    localparam logic [FN_W-1:0] FN_SRL = FN_W'(6'b000010);
    localparam logic [FN_W-1:0] FN_JR  = FN_W'(6'b001000);

    localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(4'b0000);
    localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(4'b0010);
    localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(4'b0100);
    localparam logic [ALU_W-1:0] ALU_NOR  = ALU_W'(4'b0101);
    localparam logic [ALU_W-1:0] ALU_SLL  = ALU_W'(4'b1010);
    localparam logic [ALU_W-1:0] ALU_SRL  = ALU_W'(4'b1011);
    localparam logic [ALU_W-1:0] ALU_IDLE = ALU_W'(4'b1111);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP} state_t;
    typedef enum logic [3:0] {
        C_NOP, C_HALT, C_ILL, C_R, C_JR, C_ADDI, C_ANDI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL
    } cls_t;

    state_t            state, next;
    cls_t              cls_q, dec_cls;
    logic [ALU_W-1:0]  alu_q, dec_alu;
    logic              illegal_q;

    always_comb begin
        dec_cls = C_ILL;
        dec_alu = ALU_IDLE;
        case (opcode)
            OP_R: begin
                dec_cls = C_R;
                case (funct)
                    FN_ADD:  dec_alu = ALU_ADD;
                    FN_SUB:  dec_alu = ALU_SUB;
                    FN_AND:  dec_alu = ALU_AND;
                    FN_NOR:  dec_alu = ALU_NOR;
                    FN_SLL:  dec_alu = ALU_SLL;
                    FN_SRL:  dec_alu = ALU_SRL;
                    FN_JR:   dec_cls = C_JR;
                    default: dec_cls = C_ILL;
                endcase
            end
            OP_ADDI: begin dec_cls = C_ADDI; dec_alu = ALU_ADD; end
            OP_ANDI: begin dec_cls = C_ANDI; dec_alu = ALU_AND; end
            OP_LW:   begin dec_cls = C_LW;   dec_alu = ALU_ADD; end
            OP_SW:   begin dec_cls = C_SW;   dec_alu = ALU_ADD; end
            OP_BEQ:  begin dec_cls = C_BEQ;  dec_alu = ALU_SUB; end
            OP_BNE:  begin dec_cls = C_BNE;  dec_alu = ALU_SUB; end
            OP_J:    dec_cls = C_J;
            OP_JAL:  dec_cls = C_JAL;
            OP_NOP:  dec_cls = C_NOP;
            OP_HALT: dec_cls = C_HALT;
            default: dec_cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_FETCH;
            cls_q     <= C_NOP;
            alu_q     <= ALU_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state <= next;
            if (state == S_DECODE) begin
                cls_q <= dec_cls;
                alu_q <= dec_alu;
                if (dec_cls == C_ILL) illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next       = state;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        reg_dst    = 2'd0;
        link_reg   = 5'(RA_REG);
        reg_write  = 1'b0;
        mem_to_reg = 2'd0;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_ctrl   = ALU_IDLE;
        instr_done = 1'b0;
        illegal    = illegal_q;
        halted     = 1'b0;
        case (state)
            S_FETCH: if (!stall) begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    next     = S_DECODE;
                end
            end
            S_DECODE: case (dec_cls)
                C_NOP:   begin instr_done = 1'b1; next = S_FETCH; end
                C_HALT:  next = S_HALT;
                C_ILL:   next = S_TRAP;
                default: next = S_EXEC;
            endcase
            S_EXEC: begin
                alu_ctrl = alu_q;
                case (cls_q)
                    C_R:            next = S_WB;
                    C_ADDI:         begin alu_src = 1'b1; ext_op = 1'b1; next = S_WB; end
                    C_ANDI:         begin alu_src = 1'b1; next = S_WB; end
                    C_LW, C_SW:     begin alu_src = 1'b1; ext_op = 1'b1; next = S_MEM; end
                    C_JAL:          begin pc_write = 1'b1; pc_src = 2'd2; next = S_WB; end
                    C_J:            begin pc_write = 1'b1; pc_src = 2'd2; instr_done = 1'b1; next = S_FETCH; end
                    C_JR:           begin pc_write = 1'b1; pc_src = 2'd3; instr_done = 1'b1; next = S_FETCH; end
                    C_BEQ, C_BNE: begin
                        // branch taken when zero matches the branch sense
                        if (zero == (cls_q == C_BEQ)) begin
                            pc_write = 1'b1;
                            pc_src   = 2'd1;
                        end
                        instr_done = 1'b1;
                        next       = S_FETCH;
                    end
                    default:        next = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_read  = (cls_q == C_LW);
                mem_write = (cls_q != C_LW);
                if (mem_ready) begin
                    if (cls_q == C_LW) next = S_WB;
                    else begin instr_done = 1'b1; next = S_FETCH; end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next       = S_FETCH;
                case (cls_q)
                    C_R:     reg_dst = 2'd1;
                    C_LW:    mem_to_reg = 2'd1;
                    C_JAL:   begin reg_dst = 2'd2; mem_to_reg = 2'd2; end
                    default: ;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) begin instr_done = 1'b1; next = S_FETCH; end
            end
            S_TRAP:  ;
            default: next = S_FETCH;
        endcase
        // reset forces idle outputs in the same cycle, whatever state the register holds
        if (!rst) begin
            imem_req   = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'd0;
            reg_dst    = 2'd0;
            link_reg   = 5'd0;
            reg_write  = 1'b0;
            mem_to_reg = 2'd0;
            alu_src    = 1'b0;
            ext_op     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            alu_ctrl   = ALU_IDLE;
            instr_done = 1'b0;
            illegal    = 1'b0;
            halted     = 1'b0;
            next       = S_FETCH;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction cycle model built from the instruction rules,
// replayed against the DUT with one compare on every cycle, plus literal latency pins.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0, zero = 1'b0, stall = 1'b0, resume = 1'b0, mem_ready = 1'b1;
    logic [5:0] opcode = 6'h3F, funct = 6'h00;
    logic       imem_req, ir_write, pc_write, reg_write, alu_src, ext_op;
    logic       mem_read, mem_write, instr_done, illegal, halted;
    logic [1:0] pc_src, reg_dst, mem_to_reg;
    logic [4:0] link_reg;
    logic [3:0] alu_ctrl;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .stall(stall),
        .resume(resume), .mem_ready(mem_ready), .imem_req(imem_req), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst), .link_reg(link_reg),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .ext_op(ext_op),
        .mem_read(mem_read), .mem_write(mem_write), .alu_ctrl(alu_ctrl),
        .instr_done(instr_done), .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req, ir_write, pc_write;
        logic [1:0] pc_src, reg_dst;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       alu_src, ext_op, mem_read, mem_write;
        logic [3:0] alu_ctrl;
        logic       instr_done, illegal, halted;
    } outs_t;

    typedef struct {
        logic  rst, stall, resume, mr, z;
        outs_t exp;
    } cyc_t;

    cyc_t  q[$];
    outs_t act, exp_cur, o;
    string cur_name = "";
    int    checks = 0, fails = 0, cyc_idx = 0;
    bit    chk_en = 1'b0;

    assign act = {imem_req, ir_write, pc_write, pc_src, reg_dst, reg_write, mem_to_reg,
                  alu_src, ext_op, mem_read, mem_write, alu_ctrl, instr_done, illegal, halted};

    always @(negedge clk) if (chk_en) begin
        checks++;
        if (act !== exp_cur) begin
            fails++;
            $display("FAIL %s cycle %0d: got %b expected %b", cur_name, cyc_idx, act, exp_cur);
        end
    end

    function automatic outs_t idle();
        outs_t r = '0;
        r.alu_ctrl = 4'hF;
        return r;
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b0000;
            6'b100010: return 4'b0010;
            6'b100100: return 4'b0100;
            6'b100111: return 4'b0101;
            6'b000000: return 4'b1010;
            default:   return 4'b1011;
        endcase
    endfunction

    task automatic push(input logic r, s, rs, mr, z, input outs_t e);
        cyc_t c;
        c.rst = r; c.stall = s; c.resume = rs; c.mr = mr; c.z = z; c.exp = e;
        q.push_back(c);
    endtask

    task automatic push_fetch(input int fw);
        for (int i = 0; i < fw; i++) begin o = idle(); o.imem_req = 1; push(1, 0, 0, 0, 0, o); end
        o = idle(); o.imem_req = 1; o.ir_write = 1; o.pc_write = 1; push(1, 0, 0, 1, 0, o);
    endtask

    // Expected cycle sequence of one instruction, straight from the instruction table.
    task automatic build(input logic [5:0] op, fn, input logic z, input int fw, mw);
        bit to_mem = 0, to_wb = 0, taken;
        q.delete();
        push_fetch(fw);
        o = idle();
        if (op == 6'h3F) begin o.instr_done = 1; push(1, 0, 0, 1, z, o); return; end
        push(1, 0, 0, 1, z, o);
        case (op)
            6'h00: if (fn == 6'h08) begin o.pc_write = 1; o.pc_src = 3; o.instr_done = 1; end
                   else begin o.alu_ctrl = alu_of(fn); to_wb = 1; end
            6'h08: begin o.alu_ctrl = 4'b0000; o.alu_src = 1; o.ext_op = 1; to_wb = 1; end
            6'h0C: begin o.alu_ctrl = 4'b0100; o.alu_src = 1; to_wb = 1; end
            6'h30, 6'h2B: begin o.alu_ctrl = 4'b0000; o.alu_src = 1; o.ext_op = 1; to_mem = 1; end
            6'h04, 6'h05: begin
                o.alu_ctrl = 4'b0010; o.instr_done = 1;
                taken = (op == 6'h04) ? z : !z;
                if (taken) begin o.pc_write = 1; o.pc_src = 1; end
            end
            6'h02: begin o.pc_write = 1; o.pc_src = 2; o.instr_done = 1; end
            default: begin o.pc_write = 1; o.pc_src = 2; to_wb = 1; end
        endcase
        push(1, 0, 0, 1, z, o);
        if (to_mem) begin
            for (int i = 0; i <= mw; i++) begin
                o = idle();
                if (op == 6'h30) o.mem_read = 1; else o.mem_write = 1;
                if (i == mw && op == 6'h2B) o.instr_done = 1;
                push(1, 0, 0, (i == mw), z, o);
            end
            to_wb = (op == 6'h30);
        end
        if (to_wb) begin
            o = idle(); o.reg_write = 1; o.instr_done = 1;
            if (op == 6'h00) o.reg_dst = 1;
            if (op == 6'h30) o.mem_to_reg = 1;
            if (op == 6'h03) begin o.reg_dst = 2; o.mem_to_reg = 2; end
            push(1, 0, 0, 1, z, o);
        end
    endtask

    task automatic play(input logic [5:0] op, fn, input string name);
        foreach (q[i]) begin
            @(posedge clk); #1;
            opcode = op; funct = fn; cur_name = name; cyc_idx = i + 1;
            rst = q[i].rst; stall = q[i].stall; resume = q[i].resume;
            mem_ready = q[i].mr; zero = q[i].z; exp_cur = q[i].exp; chk_en = 1'b1;
        end
    endtask

    task automatic run(input logic [5:0] op, fn, input logic z, input int fw, mw, input string name);
        build(op, fn, z, fw, mw);
        play(op, fn, name);
    endtask

    task automatic lit(input string name, input int a, input int e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    task automatic do_reset(input int n, input string name);
        q.delete();
        for (int i = 0; i < n; i++) push(0, 0, 1, 1, 0, idle());
        play(6'h3F, 6'h00, name);
    endtask

    logic [5:0] rfn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100111, 6'b000000, 6'b000010};

    initial begin
        do_reset(2, "reset");

        build(6'h00, 6'h20, 0, 0, 0); lit("lat_add", q.size(), 4); play(6'h00, 6'h20, "add");
        foreach (rfn[k]) run(6'h00, rfn[k], 0, 1, 0, "rtype");
        run(6'h08, 6'h00, 0, 0, 0, "addi");
        run(6'h0C, 6'h00, 0, 2, 0, "andi");
        build(6'h30, 6'h00, 0, 0, 3); lit("lat_lw_wait3", q.size(), 8); play(6'h30, 6'h00, "lw_wait");
        build(6'h30, 6'h00, 0, 0, 0); lit("lat_lw", q.size(), 5); play(6'h30, 6'h00, "lw");
        build(6'h2B, 6'h00, 0, 0, 0); lit("lat_sw", q.size(), 4); play(6'h2B, 6'h00, "sw");
        run(6'h2B, 6'h00, 0, 1, 2, "sw_wait");
        build(6'h04, 6'h00, 1, 0, 0); lit("lat_beq", q.size(), 3); play(6'h04, 6'h00, "beq_z1");
        run(6'h04, 6'h00, 0, 0, 0, "beq_z0");
        run(6'h05, 6'h00, 1, 0, 0, "bne_z1");
        run(6'h05, 6'h00, 0, 0, 0, "bne_z0");
        run(6'h02, 6'h00, 0, 0, 0, "j");
        build(6'h03, 6'h00, 0, 0, 0); lit("lat_jal", q.size(), 4); play(6'h03, 6'h00, "jal");
        @(negedge clk); lit("link_reg", int'(link_reg), 31);
        run(6'h00, 6'h08, 0, 0, 0, "jr");
        build(6'h3F, 6'h00, 0, 0, 0); lit("lat_nop", q.size(), 2); play(6'h3F, 6'h00, "nop");

        // stall holds FETCH even with mem_ready high; stall is ignored once past FETCH
        build(6'h00, 6'h22, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc_t c; c.rst = 1; c.stall = 1; c.resume = 0; c.mr = 1; c.z = 0; c.exp = idle();
            q.push_front(c);
        end
        for (int i = 6; i < q.size(); i++) q[i].stall = 1;
        play(6'h00, 6'h22, "stall");

        q.delete(); push_fetch(0); push(1, 0, 0, 1, 0, idle());
        o = idle(); o.halted = 1;
        for (int i = 0; i < 3; i++) push(1, 1, 0, 1, 0, o);
        o.instr_done = 1; push(1, 0, 1, 1, 0, o);
        play(6'h06, 6'h00, "halt");
        run(6'h3F, 6'h00, 0, 0, 0, "after_halt");

        // reset in the middle of a load's memory wait
        build(6'h30, 6'h00, 0, 0, 5);
        while (q.size() > 5) void'(q.pop_back());
        push(0, 0, 0, 0, 0, idle());
        play(6'h30, 6'h00, "rst_mem");
        run(6'h00, 6'h24, 0, 0, 0, "after_rst_mem");

        foreach (rfn[k]) if (k < 2) begin
            logic [5:0] op = (k == 0) ? 6'h15 : 6'h00;
            logic [5:0] fn = (k == 0) ? 6'h00 : 6'h3F;
            q.delete(); push_fetch(0); push(1, 0, 0, 1, 0, idle());
            o = idle(); o.illegal = 1;
            for (int i = 0; i < 10; i++) push(1, i[1], i[0], 1, 0, o);
            play(op, fn, "trap");
            @(negedge clk); lit("illegal_sticky", int'(illegal), 1);
            do_reset(1, "trap_reset");
            run(6'h00, 6'h27, 0, 0, 0, "after_trap");
        end

        @(posedge clk); #1 chk_en = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
